rom_burst: RTL
==============

# rom_burst

Parametrised successor to the byte-wide read-only memory. It serves multi-byte words assembled from a byte-addressed constant array, and supports counted bursts with address auto-increment and modulo wrap. A consumer stall holds the current beat. Out-of-range start addresses are flagged. It sits between the instruction/constant fetch logic and the program image, and gives one-cycle first-beat latency with back-to-back burst capability.

## Interface
- size_addr, 8, byte-address width
- size, 128, memory size in bytes; must satisfy 1 ≤ size ≤ 2^size_addr
- width_bytes, 2, bytes per output word (1..4)
- size_len, 3, burst-length field width; burst = len+1 words
- data_init, all zeros, size*8-bit image; byte i = data_init[8i+7:8i]

- clk, in, 1, clock; all state changes on rising edge
- rst_n, in, 1, reset, asynchronous and active-low
- read, in, 1, burst request; sampled only when a new burst can be accepted
- address, in, size_addr, byte start address, sampled with an accepted read
- len, in, size_len, burst length minus one, sampled with an accepted read
- stall, in, 1, consumer back-pressure; a beat is consumed when ready=1 and stall=0
- busy, out, 1, burst in progress
- ready, out, 1, data valid
- last, out, 1, current beat is the final beat of the burst
- data, out, width_bytes*8, word; little-endian, byte k = mem[(a+k) mod size]
- error, out, 1, one-cycle pulse: start address ≥ size, request rejected

## Operation
- Two states:
  - IDLE: busy=0, ready=0.
  - READ: busy=1, ready=1.
- Accept condition: read=1 and either (state IDLE) or (state READ with the final beat consumed this cycle).
- On accept with address < size:
  - state→READ.
  - Word at address is loaded into data; ready=1.
  - Remaining count := len.
  - next pointer := (address + width_bytes) mod size.
  - last := (len == 0).
- On accept with address ≥ size:
  - error=1 for one cycle.
  - state→IDLE; no beat.
- Beat consumed with count > 0:
  - Load word at pointer; pointer += width_bytes mod size; count -= 1.
  - last := (count_new == 0).
- Beat consumed with count == 0:
  - With no accept: state→IDLE; ready, last, busy → 0; data holds its last value.
  - With accept: new burst starts; ready stays 1.
- Stall=1 while ready=1: data, last, pointer and count are held unchanged.
- Read while busy and not on the final consumed beat: ignored, with no error.
- Byte wrap applies within a single word as well as between beats, for example a word spanning size-1 → 0.
- Memory contents are constant; there is no write path.

## Timing
- Reset (rst_n=0, any time, including mid-burst):
  - State IDLE.
  - busy=0, ready=0, last=0, error=0, data=0.
  - Pointer and count are cleared.
  - Takes effect immediately; the first accept is possible on the first rising edge with rst_n=1.
- Latency: read accepted at edge k → first beat has ready=1 after edge k.
- An unstalled burst of N words occupies N consecutive cycles with ready=1.
- ready deasserts after the edge that consumes the last beat, unless a back-to-back accept occurs.
- Back-to-back: zero-cycle gap; last falls and data changes on the same edge.
- error is asserted for exactly one cycle after the edge that sampled the bad address.
- All outputs are registered; there is no combinational path from inputs to outputs.

## Test plan
- Reset, read: data_init byte i = i; width_bytes=2, address=0x10, len=3, stall=0 → ready for 4 cycles; data 0x1110, 0x1312, 0x1514, 0x1716; last only on the 4th beat; busy then falls.
- Wrap: size=128, address=0x7F, len=1 → beats 0x007F, then 0x0201 (pointer wrapped to 1).
- Stall: same burst as the first scenario with stall=1 for 3 cycles on beat 2 → data holds 0x1312 throughout; the burst still finishes with 4 consumed beats in total.
- Back-to-back: read=1 on the final consumed beat with address=0x40, len=0 → ready stays high; next data 0x4140 with last=1.
- Error and ignore: address=0x90 → error pulse for one cycle, ready stays 0. A read asserted mid-burst is ignored, and beat count and data are unchanged.
- Async reset mid-burst: drop rst_n on beat 2 → all outputs are 0 immediately. After release, a new read at 0x00 returns 0x0100 one edge later.

Source files
------------

// File: rtl/rom_burst.sv
// rtl/rom_burst.sv - burst-capable multi-byte read-only memory with modulo address wrap
module rom_burst #(
    parameter int size_addr   = 8,
    parameter int size        = 128,
    parameter int width_bytes = 2,
    parameter int size_len    = 3,
    parameter logic [size*8-1:0] data_init = '0
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     read,
    input  logic [size_addr-1:0]     address,
    input  logic [size_len-1:0]      len,
    input  logic                     stall,
    output logic                     busy,
    output logic                     ready,
    output logic                     last,
    output logic [width_bytes*8-1:0] data,
    output logic                     error
);

    localparam int word_bits = width_bytes * 8;

    typedef enum logic {
        IDLE,
        READ
    } state_t;

    state_t              state;
    logic [size_addr-1:0] ptr;
    logic [size_len-1:0]  count;

    logic consume;
    logic final_beat;
    logic accept;
    logic addr_ok;

    // Assemble a little-endian word; every byte wraps independently so a word
    // may straddle the top of the image and continue at byte 0.
    function automatic logic [word_bits-1:0] word_at(input logic [size_addr-1:0] base);
        logic [word_bits-1:0] w;
        int idx;
        w = '0;
        for (int k = 0; k < width_bytes; k++) begin
            idx = (int'(base) + k) % size;
            w[8*k +: 8] = data_init[8*idx +: 8];
        end
        return w;
    endfunction

    // Start address of the following word, wrapped modulo the image size.
    function automatic logic [size_addr-1:0] next_ptr(input logic [size_addr-1:0] base);
        return size_addr'((int'(base) + width_bytes) % size);
    endfunction

    // Handshake decode: a beat leaves when presented and not stalled; a new
    // burst is taken when idle or exactly as the final beat leaves.
    always_comb begin
        consume    = ready && !stall;
        final_beat = consume && (count == '0);
        accept     = read && ((state == IDLE) || final_beat);
        addr_ok    = (int'(address) < size);
    end

    // Burst sequencer with registered outputs; a rejected start address
    // produces a one-cycle error and leaves the memory idle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            ptr   <= '0;
            count <= '0;
            busy  <= 1'b0;
            ready <= 1'b0;
            last  <= 1'b0;
            data  <= '0;
            error <= 1'b0;
        end else begin
            error <= 1'b0;
            if (accept) begin
                if (addr_ok) begin
                    state <= READ;
                    busy  <= 1'b1;
                    ready <= 1'b1;
                    data  <= word_at(address);
                    ptr   <= next_ptr(address);
                    count <= len;
                    last  <= (len == '0);
                end else begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    ready <= 1'b0;
                    last  <= 1'b0;
                    error <= 1'b1;
                end
            end else if (consume) begin
                if (count != '0) begin
                    data  <= word_at(ptr);
                    ptr   <= next_ptr(ptr);
                    count <= count - size_len'(1);
                    last  <= (count == size_len'(1));
                end else begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    ready <= 1'b0;
                    last  <= 1'b0;
                end
            end
        end
    end

endmodule
